// File: rtl/flush_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// flush_redirect_ctrl_pkg
//   Shared types and constants for the writeback-driven flush/redirect
//   sequencer: FSM state encoding, default counter sizing and the redirect
//   target selection rule.
// -----------------------------------------------------------------------------
package flush_redirect_ctrl_pkg;

  // Redirect sequencer states.
  typedef enum logic {
    FRC_IDLE  = 1'b0,
    FRC_REDIR = 1'b1
  } frc_state_e;

  // Default in-flight limit for instruction requests and the counter width
  // able to hold it (plus the one extra request that can land in an event
  // cycle).
  localparam int FRC_MAX_OUTSTANDING = 4;
  localparam int FRC_CNT_W           = 3;

  // An exception outranks ertn when both retire in the same cycle.
  function automatic logic [31:0] frc_target(input logic        exc,
                                             input logic [31:0] eentry,
                                             input logic [31:0] era);
    return exc ? eentry : era;
  endfunction

endpackage : flush_redirect_ctrl_pkg

// File: rtl/flush_redirect_ctrl_inst_outstanding_cnt.sv
// -----------------------------------------------------------------------------
// inst_outstanding_cnt
//   Tracks instruction-fetch requests in flight and, on a flush event,
//   snapshots how many of them are stale so their responses can be dropped.
//
// Ports
//   clk            in   clock
//   resetn         in   synchronous active-low reset
//   event_i        in   flush event from writeback (exception or ertn)
//   req_hs_i       in   instruction request handshake
//   resp_hs_i      in   instruction response handshake
//   out_cnt_o      out  requests currently in flight
//   disc_cnt_o     out  stale responses still to be dropped
//   discard_resp_o out  the response of this cycle belongs to a pre-flush request
// -----------------------------------------------------------------------------
module inst_outstanding_cnt
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = FRC_MAX_OUTSTANDING,
  parameter int CNT_W           = FRC_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             event_i,
  input  logic             req_hs_i,
  input  logic             resp_hs_i,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic [CNT_W-1:0] disc_cnt_o,
  output logic             discard_resp_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [CNT_W:0]   disc_load;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    out_cnt_d      = out_cnt_q;
    disc_cnt_d     = disc_cnt_q;
    disc_load      = '0;
    discard_resp_o = resp_hs_i & (disc_cnt_q != '0);

    // Simultaneous request and response cancel out; both ends saturate.
    if (req_hs_i && !resp_hs_i) begin
      if (out_cnt_q != CNT_MAX) out_cnt_d = out_cnt_q + 1'b1;
    end else if (resp_hs_i && !req_hs_i) begin
      if (out_cnt_q != '0) out_cnt_d = out_cnt_q - 1'b1;
    end

    // Everything in flight at the flush edge is stale, including a request
    // handshaked in the event cycle itself; a live response retiring in the
    // same cycle is no longer in flight.
    disc_load = {1'b0, out_cnt_q} + (CNT_W + 1)'(req_hs_i);
    if (resp_hs_i && !discard_resp_o && disc_load != '0) begin
      disc_load = disc_load - 1'b1;
    end

    if (event_i) begin
      disc_cnt_d = disc_load[CNT_W] ? '1 : disc_load[CNT_W-1:0];
    end else if (discard_resp_o) begin
      disc_cnt_d = disc_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values; reset is checked inside the clocked
    // block because it is synchronous.
    if (!resetn) begin
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  // A response with nothing in flight means the fetch interface broke
  // protocol; the counter simply holds at zero.
  always_ff @(posedge clk) begin
    if (resetn && resp_hs_i) begin
      assert (out_cnt_q != '0)
        else $error("inst_outstanding_cnt: response with no request in flight");
    end
  end

  assign out_cnt_o  = out_cnt_q;
  assign disc_cnt_o = disc_cnt_q;

endmodule : inst_outstanding_cnt

// File: rtl/flush_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// flush_redirect_ctrl
//   Writeback-driven pipeline flush/redirect sequencer. A WB exception or ertn
//   flushes IF/ID/EX/MEM in the same cycle, then a PC redirect (EENTRY or ERA)
//   is held toward pre-IF until it is accepted. Outstanding fetch requests are
//   tracked so responses to pre-flush requests can be discarded.
//
// Ports
//   clk            in   clock
//   resetn         in   synchronous active-low reset
//   wb_exc         in   WB exception (valid-qualified)
//   wb_ertn        in   WB ertn (valid-qualified)
//   csr_eentry     in   exception entry address
//   csr_era        in   exception return address
//   fetch_ready    in   pre-IF accepts the redirect this cycle
//   inst_req_hs    in   instruction request handshake
//   inst_resp_hs   in   instruction response handshake
//   flush_o        out  clear IF/ID/EX/MEM valid, block WB writes
//   redirect_valid out  redirect pending toward pre-IF
//   redirect_pc    out  redirect target
//   discard_resp   out  this cycle's response is stale
//   req_allow      out  pre-IF may issue a new instruction request
//   ctrl_busy      out  redirect pending or stale responses outstanding
// -----------------------------------------------------------------------------
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = FRC_MAX_OUTSTANDING,
  parameter int CNT_W           = FRC_CNT_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_exc,
  input  logic        wb_ertn,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        fetch_ready,
  input  logic        inst_req_hs,
  input  logic        inst_resp_hs,
  output logic        flush_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        discard_resp,
  output logic        req_allow,
  output logic        ctrl_busy
);

  frc_state_e       state_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_event;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] disc_cnt;

  assign flush_event = wb_exc | wb_ertn;

  // Redirect FSM. A new event while a redirect is pending replaces the target
  // and wins over a same-cycle fetch_ready, so the newest target is never lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= FRC_IDLE;
      redirect_pc_q <= '0;
    end else begin
      unique case (state_q)
        FRC_IDLE: begin
          if (flush_event) begin
            state_q       <= FRC_REDIR;
            redirect_pc_q <= frc_target(wb_exc, csr_eentry, csr_era);
          end
        end
        FRC_REDIR: begin
          if (flush_event) begin
            redirect_pc_q <= frc_target(wb_exc, csr_eentry, csr_era);
          end else if (fetch_ready) begin
            state_q <= FRC_IDLE;
          end
        end
        default: state_q <= FRC_IDLE;
      endcase
    end
  end

  inst_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_inst_outstanding_cnt (
    .clk            (clk),
    .resetn         (resetn),
    .event_i        (flush_event),
    .req_hs_i       (inst_req_hs),
    .resp_hs_i      (inst_resp_hs),
    .out_cnt_o      (out_cnt),
    .disc_cnt_o     (disc_cnt),
    .discard_resp_o (discard_resp)
  );

  // The event cycle flushes immediately; the flush then stays up while the
  // redirect is pending so nothing fetched on the old path can advance.
  assign flush_o        = flush_event | (state_q == FRC_REDIR);
  assign redirect_valid = (state_q == FRC_REDIR);
  assign redirect_pc    = redirect_pc_q;
  assign req_allow      = (out_cnt < CNT_W'(MAX_OUTSTANDING)) & ~flush_o;
  assign ctrl_busy      = (state_q != FRC_IDLE) | (disc_cnt != '0);

endmodule : flush_redirect_ctrl

// File: tb/tb_flush_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flush_redirect_ctrl
//   Directed bench for flush_redirect_ctrl. A reference model keeps the fetch
//   requests in flight as an ordered list of "stale" flags plus a pending
//   redirect; a compare process checks every DUT output against it on each
//   falling edge, and the directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_exc, wb_ertn;
  logic [31:0] csr_eentry, csr_era;
  logic        fetch_ready, inst_req_hs, inst_resp_hs;
  logic        flush_o, redirect_valid, discard_resp, req_allow, ctrl_busy;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  flush_redirect_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_exc         (wb_exc),
    .wb_ertn        (wb_ertn),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
    .fetch_ready    (fetch_ready),
    .inst_req_hs    (inst_req_hs),
    .inst_resp_hs   (inst_resp_hs),
    .flush_o        (flush_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .discard_resp   (discard_resp),
    .req_allow      (req_allow),
    .ctrl_busy      (ctrl_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_stale[$];  // requests in flight, oldest first; 1 = pre-flush
  bit          m_pend;
  logic [31:0] m_pc;

  always @(posedge clk) begin
    if (!resetn) begin
      m_stale.delete();
      m_pend = 1'b0;
      m_pc   = '0;
    end else begin
      if (inst_resp_hs && m_stale.size() > 0) void'(m_stale.pop_front());
      if (inst_req_hs) m_stale.push_back(1'b0);
      if (wb_exc || wb_ertn) begin
        foreach (m_stale[i]) m_stale[i] = 1'b1;
        m_pend = 1'b1;
        m_pc   = wb_exc ? csr_eentry : csr_era;
      end else if (m_pend && fetch_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  logic e_flush, e_disc, e_busy;
  always @(negedge clk) begin
    if (chk_en) begin
      e_flush = wb_exc | wb_ertn | m_pend;
      e_disc  = inst_resp_hs && (m_stale.size() > 0) && m_stale[0];
      e_busy  = m_pend;
      foreach (m_stale[i]) if (m_stale[i]) e_busy = 1'b1;
      check("m_flush",    32'(flush_o),        32'(e_flush));
      check("m_rvalid",   32'(redirect_valid), 32'(m_pend));
      check("m_rpc",      redirect_pc,         m_pc);
      check("m_discard",  32'(discard_resp),   32'(e_disc));
      check("m_reqallow", 32'(req_allow),      32'((m_stale.size() < 4) && !e_flush));
      check("m_busy",     32'(ctrl_busy),      32'(e_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then let combinational outputs settle.
  task automatic drive(input logic exc, input logic ertn, input logic fr,
                       input logic req, input logic resp);
    wb_exc       = exc;
    wb_ertn      = ertn;
    fetch_ready  = fr;
    inst_req_hs  = req;
    inst_resp_hs = resp;
    #1;
  endtask

  int nflush;
  int nrv;

  initial begin
    resetn     = 1'b0;
    csr_eentry = '0;
    csr_era    = '0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk_en = 1'b1;

    // Reset state.
    check("rst_flush",    32'(flush_o),        32'd0);
    check("rst_rvalid",   32'(redirect_valid), 32'd0);
    check("rst_pc",       redirect_pc,         32'h0);
    check("rst_reqallow", 32'(req_allow),      32'd1);
    check("rst_busy",     32'(ctrl_busy),      32'd0);
    resetn = 1'b1;

    // 1: exception, fetch_ready low for two cycles.
    tick(); csr_eentry = 32'h1C00_8000; drive(1, 0, 0, 0, 0);
    nflush = int'(flush_o);
    check("t1_flush_same_cycle", 32'(flush_o), 32'd1);
    tick(); drive(0, 0, 0, 0, 0);
    nflush += int'(flush_o);
    check("t1_rvalid", 32'(redirect_valid), 32'd1);
    check("t1_pc",     redirect_pc,         32'h1C00_8000);
    tick(); drive(0, 0, 1, 0, 0);
    nflush += int'(flush_o);
    check("t1_rvalid_accept", 32'(redirect_valid), 32'd1);
    tick(); drive(0, 0, 0, 0, 0);
    nflush += int'(flush_o);
    check("t1_flush_cycles", 32'(nflush),         32'd3);
    check("t1_idle",         32'(redirect_valid), 32'd0);
    check("t1_busy",         32'(ctrl_busy),      32'd0);

    // 2: ertn with fetch_ready already high.
    tick(); csr_era = 32'h1C00_0104; drive(0, 1, 1, 0, 0);
    nrv = int'(redirect_valid);
    tick(); drive(0, 0, 1, 0, 0);
    nrv += int'(redirect_valid);
    check("t2_pc", redirect_pc, 32'h1C00_0104);
    tick(); drive(0, 0, 0, 0, 0);
    nrv += int'(redirect_valid);
    check("t2_rvalid_cycles", 32'(nrv), 32'd1);

    // 3: exception beats ertn; a new event while pending re-latches even
    // with fetch_ready high.
    tick(); drive(1, 1, 0, 0, 0);
    tick(); csr_era = 32'h1C00_0200; drive(0, 1, 1, 0, 0);
    check("t3_both_pc", redirect_pc, 32'h1C00_8000);
    tick(); drive(0, 0, 1, 0, 0);
    check("t3_stay_redir", 32'(redirect_valid), 32'd1);
    check("t3_newest_pc",  redirect_pc,         32'h1C00_0200);
    tick(); drive(0, 0, 0, 0, 0);
    check("t3_idle", 32'(redirect_valid), 32'd0);

    // 4: two requests in flight, event with a third request in the same cycle.
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(1, 0, 0, 1, 0);
    check("t4_reqallow_flush", 32'(req_allow), 32'd0);
    tick(); drive(0, 0, 1, 0, 1);
    check("t4_disc1", 32'(discard_resp), 32'd1);
    check("t4_busy",  32'(ctrl_busy),    32'd1);
    tick(); drive(0, 0, 0, 1, 1);   // new post-redirect request
    check("t4_disc2", 32'(discard_resp), 32'd1);
    tick(); drive(0, 0, 0, 0, 1);
    check("t4_disc3", 32'(discard_resp), 32'd1);
    tick(); drive(0, 0, 0, 0, 1);
    check("t4_keep4",  32'(discard_resp), 32'd0);
    check("t4_drained", 32'(ctrl_busy),   32'd0);
    tick(); drive(0, 0, 0, 0, 0);
    check("t4_reqallow", 32'(req_allow), 32'd1);

    // 5: saturation at four in flight.
    for (int i = 0; i < 4; i++) begin
      tick(); drive(0, 0, 0, 1, 0);
    end
    tick(); drive(0, 0, 0, 0, 0);
    check("t5_full", 32'(req_allow), 32'd0);
    tick(); drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    check("t5_one_free", 32'(req_allow), 32'd1);
    tick(); drive(0, 0, 0, 1, 1);
    tick(); drive(0, 0, 0, 0, 0);
    check("t5_req_resp_same", 32'(req_allow), 32'd1);
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 0, 0);
    check("t5_full_again", 32'(req_allow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(0, 0, 0, 0, 1);
    end
    tick(); drive(0, 0, 0, 0, 0);

    // 6: reset during REDIR with two stale responses outstanding.
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 1, 0);
    tick(); csr_eentry = 32'h1C00_9000; drive(1, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    check("t6_busy_before", 32'(ctrl_busy), 32'd1);
    resetn = 1'b0;
    tick(); drive(0, 0, 0, 0, 0);
    check("t6_rvalid",   32'(redirect_valid), 32'd0);
    check("t6_pc",       redirect_pc,         32'h0);
    check("t6_flush",    32'(flush_o),        32'd0);
    check("t6_busy",     32'(ctrl_busy),      32'd0);
    check("t6_reqallow", 32'(req_allow),      32'd1);
    resetn = 1'b1;
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_flush_redirect_ctrl
